// File: rtl/add_pipe.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES registered segments.
// A single global stall (advance) moves every stage at once under valid/ready flow control.
module add_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Sub,
   input  logic             CarryIn,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [WIDTH-1:0] C,
   output logic             CarryOut,
   output logic             Overflow,
   output logic             Zero
);

   localparam int SEG = WIDTH / STAGES;

   // Per-stage registers: stage k holds result segments 0..k plus the operands still needed.
   logic             valid_q [STAGES];
   logic             carry_q [STAGES];
   logic [WIDTH-1:0] res_q   [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] bp_q    [STAGES];

   logic             nxt_valid [STAGES];
   logic             nxt_carry [STAGES];
   logic [WIDTH-1:0] nxt_res   [STAGES];
   logic [WIDTH-1:0] nxt_a     [STAGES];
   logic [WIDTH-1:0] nxt_bp    [STAGES];
   logic [SEG:0]     sum       [STAGES];

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             ovf_d, zero_d;
   logic             ovf_q, zero_q;

   assign advance = !valid_q[STAGES-1] || Out_Ready;
   assign b_eff   = Sub ? ~B : B;

   // NOTE: combinational blocks use blocking '=' so later statements see earlier results;
   // every target is assigned on every pass, so no latch can be inferred.
   always_comb begin
      nxt_valid[0] = In_Valid;
      nxt_a[0]     = A;
      nxt_bp[0]    = b_eff;
      sum[0]       = {1'b0, A[SEG-1:0]} + {1'b0, b_eff[SEG-1:0]} + {{SEG{1'b0}}, Sub ^ CarryIn};
      nxt_res[0]   = '0;
      nxt_res[0][SEG-1:0] = sum[0][SEG-1:0];
      nxt_carry[0] = sum[0][SEG];
      for (int k = 1; k < STAGES; k++) begin
         nxt_valid[k] = valid_q[k-1];
         nxt_a[k]     = a_q[k-1];
         nxt_bp[k]    = bp_q[k-1];
         sum[k]       = {1'b0, a_q[k-1][k*SEG +: SEG]} + {1'b0, bp_q[k-1][k*SEG +: SEG]}
                        + {{SEG{1'b0}}, carry_q[k-1]};
         nxt_res[k]   = res_q[k-1];
         nxt_res[k][k*SEG +: SEG] = sum[k][SEG-1:0];
         nxt_carry[k] = sum[k][SEG];
      end
   end

   // Flags come from the complete result being loaded into the final stage.
   always_comb begin
      ovf_d  = (nxt_a[STAGES-1][WIDTH-1] == nxt_bp[STAGES-1][WIDTH-1]) &&
               (nxt_res[STAGES-1][WIDTH-1] != nxt_a[STAGES-1][WIDTH-1]);
      zero_d = (nxt_res[STAGES-1] == '0);
   end

   // NOTE: sequential state uses non-blocking '<=' so all stages sample the same pre-edge values.
   // NOTE: the pipeline arrays are reset too, because C and the flags must read 0 after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            carry_q[k] <= 1'b0;
            res_q[k]   <= '0;
            a_q[k]     <= '0;
            bp_q[k]    <= '0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= nxt_valid[k];
            carry_q[k] <= nxt_carry[k];
            res_q[k]   <= nxt_res[k];
            a_q[k]     <= nxt_a[k];
            bp_q[k]    <= nxt_bp[k];
         end
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign In_Ready  = advance;
   assign Out_Valid = valid_q[STAGES-1];
   assign C         = res_q[STAGES-1];
   assign CarryOut  = carry_q[STAGES-1];
   assign Overflow  = ovf_q;
   assign Zero      = zero_q;

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: 32-bit/2-stage DUT against an arithmetic model and queue,
// plus 64-bit instances at 1, 4 and 8 stages for full-width carry ripple.
module tb_add_pipe;

   typedef struct packed {
      logic [63:0] c;
      logic        cout;
      logic        ovf;
      logic        zero;
   } res_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, sub, cin, out_valid, out_ready;
   logic [31:0] a, b, c;
   logic        cout, ovf, zero;

   logic        w_valid, w_sub, w_cin, w_rdy;
   logic [63:0] w_a, w_b;
   logic        w_ir   [3];
   logic        w_ov   [3];
   logic [63:0] w_c    [3];
   logic        w_cout [3];
   logic        w_ovf  [3];
   logic        w_zero [3];

   int checks = 0;
   int errors = 0;
   res_t exp_q [$];

   localparam int WS [3] = '{1, 4, 8};

   always #5 clk = ~clk;

   add_pipe #(.WIDTH(32), .STAGES(2)) dut (
      .clock(clk), .reset(reset), .In_Valid(in_valid), .In_Ready(in_ready),
      .A(a), .B(b), .Sub(sub), .CarryIn(cin), .Out_Valid(out_valid), .Out_Ready(out_ready),
      .C(c), .CarryOut(cout), .Overflow(ovf), .Zero(zero));

   add_pipe #(.WIDTH(64), .STAGES(1)) dut_w1 (
      .clock(clk), .reset(reset), .In_Valid(w_valid), .In_Ready(w_ir[0]),
      .A(w_a), .B(w_b), .Sub(w_sub), .CarryIn(w_cin), .Out_Valid(w_ov[0]), .Out_Ready(w_rdy),
      .C(w_c[0]), .CarryOut(w_cout[0]), .Overflow(w_ovf[0]), .Zero(w_zero[0]));

   add_pipe #(.WIDTH(64), .STAGES(4)) dut_w4 (
      .clock(clk), .reset(reset), .In_Valid(w_valid), .In_Ready(w_ir[1]),
      .A(w_a), .B(w_b), .Sub(w_sub), .CarryIn(w_cin), .Out_Valid(w_ov[1]), .Out_Ready(w_rdy),
      .C(w_c[1]), .CarryOut(w_cout[1]), .Overflow(w_ovf[1]), .Zero(w_zero[1]));

   add_pipe #(.WIDTH(64), .STAGES(8)) dut_w8 (
      .clock(clk), .reset(reset), .In_Valid(w_valid), .In_Ready(w_ir[2]),
      .A(w_a), .B(w_b), .Sub(w_sub), .CarryIn(w_cin), .Out_Valid(w_ov[2]), .Out_Ready(w_rdy),
      .C(w_c[2]), .CarryOut(w_cout[2]), .Overflow(w_ovf[2]), .Zero(w_zero[2]));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Plain integer arithmetic: unsigned result/carry, true signed range for overflow.
   function automatic res_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                  input logic s, input logic ci);
      res_t r;
      logic [64:0] mask, ux, uy, t;
      logic signed [66:0] sx, sy, st, smax, smin, sci;
      mask = (65'd1 << w) - 65'd1;
      ux   = {1'b0, x} & mask;
      uy   = {1'b0, y} & mask;
      if (!s) begin
         t      = ux + uy + {64'd0, ci};
         r.cout = (t > mask);
      end else begin
         t      = ux - uy - {64'd0, ci};
         r.cout = (ux >= uy + {64'd0, ci});
      end
      r.c = 64'(t & mask);
      sx  = $signed({2'b00, ux});
      sy  = $signed({2'b00, uy});
      if (ux[w-1]) sx = sx - $signed(67'd1 << w);
      if (uy[w-1]) sy = sy - $signed(67'd1 << w);
      sci  = $signed({66'd0, ci});
      st   = s ? (sx - sy - sci) : (sx + sy + sci);
      smax = $signed(67'd1 << (w - 1)) - 67'sd1;
      smin = -$signed(67'd1 << (w - 1));
      r.ovf  = (st > smax) || (st < smin);
      r.zero = (r.c == 64'd0);
      return r;
   endfunction

   // Scoreboard for the 32-bit DUT: every valid output cycle is checked against the oldest expectation.
   always @(negedge clk) begin
      res_t e;
      if (reset) begin
         exp_q.delete();
      end else begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
               e = exp_q[0];
               check("sb_c",    {32'd0, c},    e.c);
               check("sb_cout", {63'd0, cout}, {63'd0, e.cout});
               check("sb_ovf",  {63'd0, ovf},  {63'd0, e.ovf});
               check("sb_zero", {63'd0, zero}, {63'd0, e.zero});
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(32, {32'd0, a}, {32'd0, b}, sub, cin));
      end
   end

   task automatic run_main(input string name, input logic [31:0] ta, input logic [31:0] tb,
                           input logic ts, input logic tc, input logic [31:0] ec,
                           input logic ecout, input logic eovf, input logic ezero);
      res_t m;
      int   lat;
      m = model(32, {32'd0, ta}, {32'd0, tb}, ts, tc);
      check({name, "_model_c"},    m.c,             {32'd0, ec});
      check({name, "_model_cout"}, {63'd0, m.cout}, {63'd0, ecout});
      check({name, "_model_ovf"},  {63'd0, m.ovf},  {63'd0, eovf});
      @(posedge clk); #1;
      a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, "_latency"}, 64'(lat), 64'd2);
      check({name, "_c"},    {32'd0, c},    {32'd0, ec});
      check({name, "_cout"}, {63'd0, cout}, {63'd0, ecout});
      check({name, "_ovf"},  {63'd0, ovf},  {63'd0, eovf});
      check({name, "_zero"}, {63'd0, zero}, {63'd0, ezero});
   endtask

   task automatic run_wide();
      int lat  [3];
      bit seen [3];
      for (int i = 0; i < 3; i++) begin lat[i] = 0; seen[i] = 1'b0; end
      @(posedge clk); #1;
      w_a = '1; w_b = 64'd1; w_valid = 1'b1;
      @(posedge clk); #1;
      w_valid = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         for (int i = 0; i < 3; i++) begin
            if (!seen[i] && w_ov[i]) begin
               seen[i] = 1'b1;
               lat[i]  = cyc;
               check("wide_c",    w_c[i],              64'd0);
               check("wide_cout", {63'd0, w_cout[i]},  64'd1);
               check("wide_zero", {63'd0, w_zero[i]},  64'd1);
            end
         end
         if (seen[0] && seen[1] && seen[2]) break;
         @(posedge clk); #1;
      end
      for (int i = 0; i < 3; i++) check("wide_latency", 64'(lat[i]), 64'(WS[i]));
   endtask

   initial begin
      int sent, guard;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
      w_valid = 1'b0; w_sub = 1'b0; w_cin = 1'b0; w_rdy = 1'b1; w_a = '0; w_b = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_c",         {32'd0, c},         64'd0);
      check("rst_cout",      {63'd0, cout},      64'd0);
      check("rst_ovf",       {63'd0, ovf},       64'd0);
      check("rst_zero",      {63'd0, zero},      64'd0);
      check("rst_in_ready",  {63'd0, in_ready},  64'd1);

      run_main("wrap",     32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      run_main("ovf_add",  32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      run_main("borrow",   32'd5,         32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      run_main("sub_zero", 32'd5,         32'd4, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      run_main("seg_cin",  32'h0000_FFFF, 32'd0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
      run_main("ovf_sub",  32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

      // Random stream with a randomly stalling consumer.
      sent = 0; guard = 0;
      while (sent < 16 && guard < 2000) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 1) == 1);
         a   = $urandom;
         b   = $urandom;
         sub = $urandom_range(0, 1) == 1;
         cin = $urandom_range(0, 1) == 1;
         @(negedge clk);
         if (in_valid && in_ready) sent++;
         guard++;
      end
      check("stream_sent", 64'(sent), 64'd16);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("stream_drained", 64'(exp_q.size()), 64'd0);

      // Reset with two beats in flight.
      @(posedge clk); #1;
      a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      a = 32'h0F0F_0F0F;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("inflight_out_valid", {63'd0, out_valid}, 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("flush_out_valid", {63'd0, out_valid}, 64'd0);
      check("flush_c",         {32'd0, c},         64'd0);
      check("flush_cout",      {63'd0, cout},      64'd0);
      check("flush_ovf",       {63'd0, ovf},       64'd0);
      check("flush_zero",      {63'd0, zero},      64'd0);
      reset = 1'b0; out_ready = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         check("no_stale_beat", {63'd0, out_valid}, 64'd0);
      end

      run_wide();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
